// File: rtl/zx_kbd_pkg.sv
// Shared constants for the ZX keyboard/mouse receiver: matrix geometry,
// frame layout and register reset values.
package zx_kbd_pkg;
    localparam int KBD_ROWS        = 8;
    localparam int KBD_COLS        = 5;
    localparam int KBD_KEYS        = KBD_ROWS * KBD_COLS;
    localparam int KBD_FRAME_BYTES = 5;

    localparam logic [2:0] KBD_EXP_BAD = 3'd7;
    localparam logic [7:0] MUS_BTN_RST = 8'hFF;
endpackage

// File: rtl/kbd_frame_asm.sv
// Keyboard frame assembler: tracks the expected byte index, collects bytes 0..3
// in a shadow and commits the full 40-bit matrix when byte 4 arrives in order.
module kbd_frame_asm
    import zx_kbd_pkg::*;
(
    input  logic                fclk,
    input  logic                rst,
    input  logic [7:0]          i_kbd_in,
    input  logic [2:0]          i_kbd_sel,
    input  logic                i_kbd_stb,
    input  logic                i_clr,
    output logic [KBD_KEYS-1:0] o_active,
    output logic                o_commit,
    output logic                o_upd,
    output logic                o_ferr
);
    localparam logic [2:0] LAST_SEL = 3'(KBD_FRAME_BYTES - 1);
    localparam logic [2:0] PAD_EXP  = 3'(KBD_FRAME_BYTES);

    logic [2:0]          r_exp;
    logic [31:0]         r_shadow;
    logic [KBD_KEYS-1:0] r_active;
    logic                r_upd;
    logic                r_ferr;

    logic       w_store;
    logic       w_commit;
    logic       w_ferr;
    logic [2:0] w_exp_nxt;

    always_comb begin
        w_store   = 1'b0;
        w_commit  = 1'b0;
        w_ferr    = 1'b0;
        w_exp_nxt = r_exp;
        if (i_kbd_stb) begin
            if (i_kbd_sel == 3'd0) begin
                w_store   = 1'b1;
                w_exp_nxt = 3'd1;
            end else if (i_kbd_sel == r_exp && r_exp >= 3'd1 && r_exp < LAST_SEL) begin
                w_store   = 1'b1;
                w_exp_nxt = r_exp + 3'd1;
            end else if (i_kbd_sel == LAST_SEL && r_exp == LAST_SEL) begin
                w_commit  = 1'b1;
                w_exp_nxt = PAD_EXP;
            end else if (!(r_exp == PAD_EXP && i_kbd_sel >= PAD_EXP)) begin
                // padding bytes after a completed frame are silently dropped
                w_ferr    = 1'b1;
                w_exp_nxt = KBD_EXP_BAD;
            end
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_exp    <= 3'd0;
            r_shadow <= '0;
            r_active <= '0;
            r_upd    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_exp  <= w_exp_nxt;
            r_upd  <= w_commit;
            r_ferr <= w_ferr;
            if (w_store)
                r_shadow[{i_kbd_sel[1:0], 3'b000} +: 8] <= i_kbd_in;
            if (w_commit)
                r_active <= {i_kbd_in, r_shadow};
            else if (i_clr)
                r_active <= '0;
        end
    end

    assign o_active = r_active;
    assign o_commit = w_commit;
    assign o_upd    = r_upd;
    assign o_ferr   = r_ferr;
endmodule

// File: rtl/zx_kbd_mus.sv
// ZX keyboard/mouse receiver top: frame timeout, port #FE column decode and
// mouse/Kempston byte registers fed from the AVR SPI stage.
module zx_kbd_mus
    import zx_kbd_pkg::*;
#(
    parameter int TMO_W = 24
) (
    input  logic                fclk,
    input  logic                rst,
    input  logic [7:0]          kbd_in,
    input  logic [2:0]          kbd_in_sel,
    input  logic                kbd_stb,
    input  logic [7:0]          mus_in,
    input  logic                mus_xstb,
    input  logic                mus_ystb,
    input  logic                mus_btnstb,
    input  logic                kj_stb,
    input  logic [7:0]          kbd_row,
    output logic [KBD_COLS-1:0] kbd_cols,
    output logic                kbd_upd,
    output logic                kbd_ferr,
    output logic                kbd_tmo,
    output logic [7:0]          mus_x,
    output logic [7:0]          mus_y,
    output logic [7:0]          mus_btn,
    output logic [7:0]          kj_data
);
    logic [TMO_W-1:0]    r_cnt;
    logic [7:0]          r_mus_x;
    logic [7:0]          r_mus_y;
    logic [7:0]          r_mus_btn;
    logic [7:0]          r_kj;

    logic [KBD_KEYS-1:0] w_active;
    logic [KBD_KEYS-1:0] w_matrix;
    logic [KBD_COLS-1:0] w_hit;
    logic                w_commit;
    logic                w_sat;

    assign w_sat = &r_cnt;

    kbd_frame_asm u_frame_asm (
        .fclk      (fclk),
        .rst       (rst),
        .i_kbd_in  (kbd_in),
        .i_kbd_sel (kbd_in_sel),
        .i_kbd_stb (kbd_stb),
        .i_clr     (w_sat & ~w_commit),
        .o_active  (w_active),
        .o_commit  (w_commit),
        .o_upd     (kbd_upd),
        .o_ferr    (kbd_ferr)
    );

    always_ff @(posedge fclk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_commit)
            r_cnt <= '0;
        else if (!w_sat)
            r_cnt <= r_cnt + 1'b1;
    end

    // mask during timeout so keys release in the same cycle the counter saturates
    assign w_matrix = w_sat ? '0 : w_active;

    always_comb begin
        w_hit = '0;
        for (int r = 0; r < KBD_ROWS; r++) begin
            if (!kbd_row[r]) begin
                for (int c = 0; c < KBD_COLS; c++)
                    w_hit[c] = w_hit[c] | w_matrix[r*KBD_COLS + c];
            end
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_mus_x   <= 8'h00;
            r_mus_y   <= 8'h00;
            r_mus_btn <= MUS_BTN_RST;
            r_kj      <= 8'h00;
        end else begin
            if (mus_xstb)   r_mus_x   <= mus_in;
            if (mus_ystb)   r_mus_y   <= mus_in;
            if (mus_btnstb) r_mus_btn <= mus_in;
            if (kj_stb)     r_kj      <= mus_in;
        end
    end

    assign kbd_cols = ~w_hit;
    assign kbd_tmo  = w_sat;
    assign mus_x    = r_mus_x;
    assign mus_y    = r_mus_y;
    assign mus_btn  = r_mus_btn;
    assign kj_data  = r_kj;
endmodule

// File: tb/tb_zx_kbd_mus.sv
// Directed bench for zx_kbd_mus with a 4-bit frame timeout (saturates after 15 cycles).
module tb_zx_kbd_mus;
    logic       fclk = 1'b0;
    logic       rst;
    logic [7:0] kbd_in;
    logic [2:0] kbd_in_sel;
    logic       kbd_stb;
    logic [7:0] mus_in;
    logic       mus_xstb, mus_ystb, mus_btnstb, kj_stb;
    logic [7:0] kbd_row;
    logic [4:0] kbd_cols;
    logic       kbd_upd, kbd_ferr, kbd_tmo;
    logic [7:0] mus_x, mus_y, mus_btn, kj_data;

    int n_total = 0;
    int n_fail  = 0;

    zx_kbd_mus #(.TMO_W(4)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .kbd_in     (kbd_in),
        .kbd_in_sel (kbd_in_sel),
        .kbd_stb    (kbd_stb),
        .mus_in     (mus_in),
        .mus_xstb   (mus_xstb),
        .mus_ystb   (mus_ystb),
        .mus_btnstb (mus_btnstb),
        .kj_stb     (kj_stb),
        .kbd_row    (kbd_row),
        .kbd_cols   (kbd_cols),
        .kbd_upd    (kbd_upd),
        .kbd_ferr   (kbd_ferr),
        .kbd_tmo    (kbd_tmo),
        .mus_x      (mus_x),
        .mus_y      (mus_y),
        .mus_btn    (mus_btn),
        .kj_data    (kj_data)
    );

    always #5 fclk = ~fclk;

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] sel, input logic [7:0] data);
        kbd_in     = data;
        kbd_in_sel = sel;
        kbd_stb    = 1'b1;
        tick();
        kbd_stb    = 1'b0;
    endtask

    task automatic cols_at(input string tag, input logic [7:0] row, input logic [4:0] exp);
        kbd_row = row;
        #1;
        check(tag, {3'b000, kbd_cols}, {3'b000, exp});
    endtask

    task automatic send_frame(input logic [39:0] m);
        send(3'd0, m[7:0]);
        send(3'd1, m[15:8]);
        send(3'd2, m[23:16]);
        send(3'd3, m[31:24]);
        send(3'd4, m[39:32]);
    endtask

    initial begin
        rst = 1'b1; kbd_in = 8'h00; kbd_in_sel = 3'd0; kbd_stb = 1'b0;
        mus_in = 8'h00; mus_xstb = 1'b0; mus_ystb = 1'b0; mus_btnstb = 1'b0; kj_stb = 1'b0;
        kbd_row = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_cols", {3'b000, kbd_cols}, 8'h1F);
        check("rst_upd", {7'd0, kbd_upd}, 8'h00);
        check("rst_ferr", {7'd0, kbd_ferr}, 8'h00);
        check("rst_tmo", {7'd0, kbd_tmo}, 8'h00);
        check("rst_mus_x", mus_x, 8'h00);
        check("rst_mus_y", mus_y, 8'h00);
        check("rst_mus_btn", mus_btn, 8'hFF);
        check("rst_kj", kj_data, 8'h00);

        // key row0/col0
        send_frame(40'h00_0000_0001);
        check("f1_upd", {7'd0, kbd_upd}, 8'h01);
        cols_at("f1_row0", 8'hFE, 5'h1E);
        cols_at("f1_row1", 8'hFD, 5'h1F);
        tick();
        check("f1_upd_once", {7'd0, kbd_upd}, 8'h00);

        // bit 39 (row7 col4) and bit 5 (row1 col0)
        send_frame(40'h80_0000_0020);
        check("f2_upd", {7'd0, kbd_upd}, 8'h01);
        cols_at("f2_rows17", 8'h7D, 5'h0E);
        cols_at("f2_none", 8'hFF, 5'h1F);
        cols_at("f2_row0_replaced", 8'hFE, 5'h1F);

        send(3'd5, 8'hAA);
        check("pad_ferr", {7'd0, kbd_ferr}, 8'h00);
        check("pad_upd", {7'd0, kbd_upd}, 8'h00);

        send(3'd0, 8'h01);
        send(3'd1, 8'h00);
        send(3'd3, 8'h00);
        check("skip_ferr", {7'd0, kbd_ferr}, 8'h01);
        check("skip_upd", {7'd0, kbd_upd}, 8'h00);
        cols_at("skip_matrix_kept", 8'h7D, 5'h0E);
        tick();
        check("skip_ferr_once", {7'd0, kbd_ferr}, 8'h00);

        // recovery frame; counter restarts at the commit edge
        send_frame(40'h00_0000_0001);
        check("rec_upd", {7'd0, kbd_upd}, 8'h01);
        cols_at("rec_row0", 8'hFE, 5'h1E);
        repeat (14) tick();
        check("tmo_pre", {7'd0, kbd_tmo}, 8'h00);
        cols_at("tmo_pre_cols", 8'hFE, 5'h1E);
        tick();
        check("tmo_on", {7'd0, kbd_tmo}, 8'h01);
        cols_at("tmo_on_cols", 8'hFE, 5'h1F);
        repeat (3) tick();
        check("tmo_hold", {7'd0, kbd_tmo}, 8'h01);
        send_frame(40'h00_0000_0001);
        check("tmo_clear", {7'd0, kbd_tmo}, 8'h00);
        cols_at("tmo_key_back", 8'hFE, 5'h1E);

        mus_in = 8'h12; mus_xstb = 1'b1; kj_stb = 1'b1;
        tick();
        mus_xstb = 1'b0; kj_stb = 1'b0;
        check("mus_x", mus_x, 8'h12);
        check("kj_both", kj_data, 8'h12);
        check("mus_y_kept", mus_y, 8'h00);
        check("mus_btn_kept", mus_btn, 8'hFF);
        mus_in = 8'h05; kj_stb = 1'b1;
        tick();
        kj_stb = 1'b0;
        check("kj", kj_data, 8'h05);
        check("mus_x_kept", mus_x, 8'h12);
        mus_in = 8'h34; mus_ystb = 1'b1;
        tick();
        mus_ystb = 1'b0;
        mus_in = 8'h0A; mus_btnstb = 1'b1;
        tick();
        mus_btnstb = 1'b0;
        check("mus_y", mus_y, 8'h34);
        check("mus_btn", mus_btn, 8'h0A);

        // reset in the middle of a frame
        send_frame(40'h00_0000_0001);
        send(3'd0, 8'h01);
        send(3'd1, 8'h00);
        send(3'd2, 8'h00);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        cols_at("mrst_cols", 8'hFE, 5'h1F);
        check("mrst_mus_x", mus_x, 8'h00);
        check("mrst_mus_btn", mus_btn, 8'hFF);
        check("mrst_kj", kj_data, 8'h00);
        check("mrst_tmo", {7'd0, kbd_tmo}, 8'h00);
        send(3'd3, 8'h00);
        check("mrst_sel3_ferr", {7'd0, kbd_ferr}, 8'h01);
        send(3'd4, 8'h00);
        check("mrst_sel4_ferr", {7'd0, kbd_ferr}, 8'h01);
        check("mrst_no_upd", {7'd0, kbd_upd}, 8'h00);
        cols_at("mrst_cols_after", 8'hFE, 5'h1F);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
